// File: rtl/mmu_bus_arbiter.sv
// Arbitrates IF/MEM/TLB-write requesters over one TLB port and a Wishbone bus; access = lookup, bus, done.
// Latency: 3 cycles min (ack on bus_ack+1), 2 on TLB/decode fault, 1 for TLB write; requesters hold req until ack.
module mmu_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic [2:0]  if_exc,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic [2:0]  mem_exc,

    input  logic        tlbw_req,
    input  logic [3:0]  tlbw_index,
    input  logic [63:0] tlbw_data,
    output logic        tlbw_ack,

    output logic [31:0] mmu_addr,
    output logic        mmu_write,
    output logic        tlb_ce,
    input  logic [31:0] tlb_addr,
    input  logic [15:0] tlb_select,
    input  logic        excepttype_is_tlbl,
    input  logic        excepttype_is_tlbs,
    input  logic        excepttype_is_tlbm,

    output logic        tlb_we,
    output logic [3:0]  tlb_index,
    output logic [63:0] tlb_data,

    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_byte,
    output logic [15:0] bus_slave,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TLBW   = 3'd1;
    localparam logic [2:0] S_LOOKUP = 3'd2;
    localparam logic [2:0] S_BUS    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] EXC_NONE   = 3'd0;
    localparam logic [2:0] EXC_TLBL   = 3'd1;
    localparam logic [2:0] EXC_TLBS   = 3'd2;
    localparam logic [2:0] EXC_MOD    = 3'd3;
    localparam logic [2:0] EXC_BUSERR = 3'd4;

    localparam int             TW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LIM     = TW'(TIMEOUT);
    localparam logic [2:0]     STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0]    state;
    logic          gnt_if;
    logic [31:0]   lat_addr;
    logic          lat_we;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_sel;
    logic [3:0]    lat_index;
    logic [63:0]   lat_tdata;
    logic [31:0]   lat_paddr;
    logic [15:0]   lat_slave;
    logic [2:0]    starve_cnt;
    logic [TW-1:0] to_cnt;

    logic          starve_hit;
    logic          grant_mem;
    logic          grant_if;
    logic          timed_out;
    logic [2:0]    lookup_exc;
    logic          res_vld;
    logic [31:0]   res_rdata;
    logic [2:0]    res_exc;

    // TLB writes always win; MEM wins over IF until IF has been passed over STARVE_MAX times.
    assign starve_hit = (starve_cnt == STARVE_LIM) && if_req;
    assign grant_mem  = !tlbw_req && mem_req && !starve_hit;
    assign grant_if   = !tlbw_req && if_req && !grant_mem;
    assign timed_out  = (to_cnt == TO_LIM);

    always_comb begin
        lookup_exc = EXC_NONE;
        if (excepttype_is_tlbm)      lookup_exc = EXC_MOD;
        else if (excepttype_is_tlbs) lookup_exc = EXC_TLBS;
        else if (excepttype_is_tlbl) lookup_exc = EXC_TLBL;
        else if (tlb_select == 16'h0) lookup_exc = EXC_BUSERR;
    end

    always_comb begin
        res_vld   = 1'b0;
        res_rdata = 32'h0;
        res_exc   = EXC_NONE;
        case (state)
            S_LOOKUP: begin
                if (lookup_exc != EXC_NONE) begin
                    res_vld = 1'b1;
                    res_exc = lookup_exc;
                end
            end
            S_BUS: begin
                if (bus_ack) begin
                    res_vld   = 1'b1;
                    res_rdata = bus_dat_i;
                end else if (timed_out) begin
                    res_vld = 1'b1;
                    res_exc = EXC_BUSERR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gnt_if    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'h0;
            lat_sel   <= 4'h0;
            lat_index <= 4'h0;
            lat_tdata <= 64'h0;
            lat_paddr <= 32'h0;
            lat_slave <= 16'h0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tlbw_req) begin
                        lat_index <= tlbw_index;
                        lat_tdata <= tlbw_data;
                        state     <= S_TLBW;
                    end else if (grant_mem) begin
                        gnt_if    <= 1'b0;
                        lat_addr  <= mem_addr;
                        lat_we    <= mem_we;
                        lat_wdata <= mem_wdata;
                        lat_sel   <= mem_sel;
                        state     <= S_LOOKUP;
                    end else if (grant_if) begin
                        gnt_if    <= 1'b1;
                        lat_addr  <= if_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= 32'h0;
                        lat_sel   <= 4'hF;
                        state     <= S_LOOKUP;
                    end
                end
                S_TLBW: state <= S_IDLE;
                S_LOOKUP: begin
                    lat_paddr <= tlb_addr;
                    lat_slave <= tlb_select;
                    to_cnt    <= '0;
                    state     <= res_vld ? S_DONE : S_BUS;
                end
                S_BUS: begin
                    if (res_vld) state  <= S_DONE;
                    else         to_cnt <= to_cnt + TW'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers per requester so the idle requester's outputs keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata  <= 32'h0;
            if_exc    <= EXC_NONE;
            mem_rdata <= 32'h0;
            mem_exc   <= EXC_NONE;
        end else if (res_vld) begin
            if (gnt_if) begin
                if_rdata <= res_rdata;
                if_exc   <= res_exc;
            end else begin
                mem_rdata <= res_rdata;
                mem_exc   <= res_exc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= 3'd0;
        else if (!if_req)
            starve_cnt <= 3'd0;
        else if (state == S_IDLE && grant_if)
            starve_cnt <= 3'd0;
        else if (state == S_IDLE && grant_mem && starve_cnt != 3'd7)
            starve_cnt <= starve_cnt + 3'd1;
    end

    assign if_ack    = (state == S_DONE) && gnt_if;
    assign mem_ack   = (state == S_DONE) && !gnt_if;
    assign tlbw_ack  = (state == S_TLBW);
    assign tlb_we    = (state == S_TLBW);
    assign tlb_index = lat_index;
    assign tlb_data  = lat_tdata;
    assign tlb_ce    = (state == S_LOOKUP);
    assign mmu_addr  = lat_addr;
    assign mmu_write = lat_we;
    assign bus_cyc   = (state == S_BUS);
    assign bus_stb   = (state == S_BUS);
    assign bus_we    = (state == S_BUS) && lat_we;
    assign bus_adr   = lat_paddr;
    assign bus_dat_o = lat_wdata;
    assign bus_byte  = lat_sel;
    assign bus_slave = lat_slave;

endmodule
